host_cmd_sequencer: RTL
=======================

// Module: host_cmd_sequencer
// PURPOSE
// Parametrised, synthesizable successor to hand-written host-command test sequences. Plays a
// loadable script of (cmd,data,gap) entries into the RemoteComm host UART, one entry at a time.
// Waits for each response, checks it against the ACK byte, and retries on timeout/NACK.
// Reports per-run pass/fail status. Sits beside RemoteComm in bench or bring-up top levels.
// PARAMETERS
// DEPTH        16       script entries (power of 2, >=2)
// CMD_W        8        command width
// DATA_W       16       data width
// GAP_W        20       width of post-ACK idle gap field (cycles)
// TIMEOUT_CYC  1000000  max cycles from cmd_sent to resp_rdy before timeout
// MAX_RETRY    2        re-sends allowed per entry after first attempt
// ACK          8'hA5    expected positive response byte
// ABORT_ON_ERR 0        1: stop run on first failed entry; 0: log fail, continue
// PORTS
// clk          in   1               system clock
// rst          in   1               synchronous, active-high reset
// ld_we        in   1               script write strobe (accepted only when !busy)
// ld_addr      in   $clog2(DEPTH)   script write address
// ld_cmd       in   CMD_W           entry command
// ld_data      in   DATA_W          entry data
// ld_gap       in   GAP_W           idle cycles after ACK before next entry
// num_ent      in   $clog2(DEPTH)+1 entries to run (0 => done immediately, pass=1)
// start        in   1               pulse: begin run at entry 0 (ignored when busy)
// cmd          out  CMD_W           to RemoteComm, registered
// data         out  DATA_W          to RemoteComm, registered
// send_cmd     out  1               one-cycle pulse to RemoteComm
// cmd_sent     in   1               RemoteComm: command fully transmitted (pulse)
// resp_rdy     in   1               RemoteComm: response byte valid (level)
// resp         in   8               RemoteComm response byte
// clr_resp_rdy out  1               one-cycle pulse knocking down resp_rdy
// busy         out  1               run in progress
// done         out  1               one-cycle pulse at run end
// pass         out  1               sticky: last run had zero failed entries
// fail_cnt     out  $clog2(DEPTH)+1 failed entries in last run
// cur_idx      out  $clog2(DEPTH)   entry being processed
// last_err     out  2               00 none, 01 timeout, 10 NACK (last failing entry)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, retry/timer counters 0; script RAM contents unchanged.
// - Script: DEPTH x (CMD_W+DATA_W+GAP_W) RAM, written in IDLE/DONE only; ld_we while busy is dropped.
// - States: IDLE -> ISSUE -> WAIT_SENT -> WAIT_RESP -> CHECK -> GAP -> (ISSUE | DONE) -> IDLE.
// - IDLE: start && num_ent!=0 -> ISSUE, busy=1, idx=0, fail_cnt=0; start && num_ent==0 -> DONE.
// - ISSUE: cmd/data loaded from RAM[idx]; send_cmd asserted exactly one cycle later; -> WAIT_SENT.
// - WAIT_SENT: wait cmd_sent; timer starts the cycle after cmd_sent; -> WAIT_RESP.
// - WAIT_RESP: resp_rdy -> CHECK, clr_resp_rdy pulsed same cycle; timer==TIMEOUT_CYC-1 -> timeout.
// - resp_rdy and timeout expiry in the same cycle: response wins.
// - CHECK: resp==ACK -> GAP, load gap counter with ld_gap entry value; else NACK.
// - Timeout/NACK: retries<MAX_RETRY -> retries++, ISSUE same idx; otherwise fail_cnt++,
//   last_err updated, and ABORT_ON_ERR ? DONE : GAP with gap=0.
// - GAP: count down gap cycles (0 => single pass-through cycle); retries=0; idx==num_ent-1 -> DONE, else idx++ -> ISSUE.
// - DONE: one cycle; done=1, busy=0, pass=(fail_cnt==0); -> IDLE. start in DONE is ignored.
// - rst mid-run: immediate return to IDLE, no further send_cmd; in-flight UART frame is not cancelled.
// - Timer width is $clog2(TIMEOUT_CYC)+1; saturates and never wraps.
// TESTING
// 1 load {06,xxxx,0},{05,00FF,10},{02,0100,0}; num_ent=3; ACK every cmd -> 3 send_cmd pulses, done, pass=1, fail_cnt=0
// 2 entry 0 never answered, MAX_RETRY=2 -> 3 send_cmd pulses spaced >=TIMEOUT_CYC; fail_cnt=1, last_err=01
// 3 first resp=8'hFF, retry resp=A5 -> 2 sends, pass=1, clr_resp_rdy pulsed twice
// 4 ABORT_ON_ERR=1, entry 1 NACKs 3 times, num_ent=4 -> done after entry 1, cur_idx=1, fail_cnt=1
// 5 resp_rdy arrives on the timeout cycle -> counted as response, no retry
// 6 ld_we during run ignored; rst mid-WAIT_RESP -> busy=0 next cycle, no send_cmd; num_ent=0 -> done, pass=1

Source files
------------

// File: rtl/host_cmd_sequencer_if.sv
// rtl/host_cmd_sequencer_if.sv - command/response handshake between the sequencer and RemoteComm
// The master side issues commands and consumes responses; the slave side is the host UART.
interface host_cmd_sequencer_if #(
  parameter int CMD_W  = 8,
  parameter int DATA_W = 16
);
  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] data;
  logic              send_cmd;
  logic              cmd_sent;
  logic              resp_rdy;
  logic [7:0]        resp;
  logic              clr_resp_rdy;

  modport master (
    output cmd, data, send_cmd, clr_resp_rdy,
    input  cmd_sent, resp_rdy, resp
  );

  modport slave (
    input  cmd, data, send_cmd, clr_resp_rdy,
    output cmd_sent, resp_rdy, resp
  );
endinterface

// File: rtl/host_cmd_sequencer.sv
// rtl/host_cmd_sequencer.sv - plays a loadable (cmd,data,gap) script into RemoteComm
// Each entry is sent, its response checked against ACK, retried on timeout/NACK, and the run scored.
module host_cmd_sequencer #(
  parameter int         DEPTH        = 16,
  parameter int         CMD_W        = 8,
  parameter int         DATA_W       = 16,
  parameter int         GAP_W        = 20,
  parameter int         TIMEOUT_CYC  = 1000000,
  parameter int         MAX_RETRY    = 2,
  parameter logic [7:0] ACK          = 8'hA5,
  parameter bit         ABORT_ON_ERR = 1'b0,
  localparam int        AW           = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_we,
  input  logic [AW-1:0]     ld_addr,
  input  logic [CMD_W-1:0]  ld_cmd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [GAP_W-1:0]  ld_gap,
  input  logic [AW:0]       num_ent,
  input  logic              start,
  host_cmd_sequencer_if.master rc,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [AW:0]       fail_cnt,
  output logic [AW-1:0]     cur_idx,
  output logic [1:0]        last_err
);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam int EW = CMD_W + DATA_W + GAP_W;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_SENT, WAIT_RESP, CHECK, GAP, DONE} state_t;

  state_t            state, state_d;
  logic [EW-1:0]     script [DEPTH];
  logic [EW-1:0]     ent;
  logic [AW-1:0]     idx;
  logic [AW:0]       nent_q;
  logic [RW-1:0]     retries;
  logic [TW-1:0]     timer;
  logic [GAP_W-1:0]  gap_cnt;
  logic [7:0]        resp_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] data_q;
  logic              send_q;
  logic              clr_d;
  logic              is_last;
  logic              retry_evt;
  logic              fail_evt;
  logic [1:0]        err_code;

  assign busy            = (state != IDLE) && (state != DONE);
  assign done            = (state == DONE);
  assign cur_idx         = idx;
  assign ent             = script[idx];
  assign rc.cmd          = cmd_q;
  assign rc.data         = data_q;
  assign rc.send_cmd     = send_q;
  assign rc.clr_resp_rdy = clr_d;

  // Script RAM is deliberately outside reset so a reset never loses a loaded script.
  always_ff @(posedge clk) begin
    if (ld_we && !busy) begin
      script[ld_addr] <= {ld_cmd, ld_data, ld_gap};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    clr_d     = 1'b0;
    retry_evt = 1'b0;
    fail_evt  = 1'b0;
    err_code  = 2'b00;
    is_last   = ({1'b0, idx} == (nent_q - (AW+1)'(1)));
    unique case (state)
      IDLE:      if (start) state_d = (num_ent != '0) ? ISSUE : DONE;
      ISSUE:     state_d = WAIT_SENT;
      WAIT_SENT: if (rc.cmd_sent) state_d = WAIT_RESP;
      // A response arriving on the expiry cycle is taken as a response.
      WAIT_RESP: begin
        if (rc.resp_rdy) begin
          clr_d   = 1'b1;
          state_d = CHECK;
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          err_code = 2'b01;
        end
      end
      CHECK:     if (resp_q == ACK) state_d = GAP; else err_code = 2'b10;
      GAP:       if (gap_cnt <= GAP_W'(1)) state_d = is_last ? DONE : ISSUE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (err_code != 2'b00) begin
      if (retries < RW'(MAX_RETRY)) begin
        retry_evt = 1'b1;
        state_d   = ISSUE;
      end else begin
        fail_evt = 1'b1;
        state_d  = ABORT_ON_ERR ? DONE : GAP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      nent_q   <= '0;
      retries  <= '0;
      timer    <= '0;
      gap_cnt  <= '0;
      resp_q   <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      send_q   <= 1'b0;
      fail_cnt <= '0;
      last_err <= 2'b00;
      pass     <= 1'b0;
    end else begin
      send_q <= (state == ISSUE);
      if (state == ISSUE) begin
        cmd_q  <= ent[EW-1 -: CMD_W];
        data_q <= ent[GAP_W +: DATA_W];
      end
      if (state == IDLE && start) begin
        idx      <= '0;
        nent_q   <= num_ent;
        retries  <= '0;
        fail_cnt <= '0;
        last_err <= 2'b00;
      end
      // Timer saturates rather than wrapping; it restarts the cycle after cmd_sent.
      if (state == WAIT_SENT && rc.cmd_sent) begin
        timer <= '0;
      end else if (state == WAIT_RESP && timer != {TW{1'b1}}) begin
        timer <= timer + TW'(1);
      end
      if (state == WAIT_RESP && rc.resp_rdy) resp_q <= rc.resp;
      if (state == CHECK && err_code == 2'b00) gap_cnt <= ent[GAP_W-1:0];
      if (retry_evt) retries <= retries + RW'(1);
      if (fail_evt) begin
        fail_cnt <= fail_cnt + (AW+1)'(1);
        last_err <= err_code;
        gap_cnt  <= '0;
      end
      if (state == GAP) begin
        retries <= '0;
        if (gap_cnt > GAP_W'(1)) begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end else if (!is_last) begin
          idx <= idx + AW'(1);
        end
      end
      if (state == DONE) pass <= (fail_cnt == '0);
    end
  end
endmodule
